// File: rtl/iiitb_pwm_btn_cond.sv
// Two-channel push-button conditioner: synchronise, debounce and arbitrate raw pad
// buttons into single-cycle duty commands. Define IIITB_BTN_AUTOREPEAT_EN for hold-to-repeat.

module iiitb_pwm_btn_cond_chan #(
   parameter int DB_CYCLES     = 16,
   parameter int REPEAT_DELAY  = 64,
   parameter int REPEAT_PERIOD = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   input  logic pulse_busy,
   output logic req,
   output logic held_next
);

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      HELD,
      DEB_RELEASE
   } state_t;

   localparam logic [15:0] DB_LIMIT = 16'(DB_CYCLES);

   if (DB_CYCLES < 2 || DB_CYCLES > 65535 ||
       REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
       REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_params
      $error("iiitb_pwm_btn_cond: timing parameter out of range");
   end

   logic        sync_meta;
   logic        sync;
   state_t      state;
   state_t      state_next;
   logic [15:0] db_cnt;
   logic [15:0] db_cnt_next;
   logic        press_req;
   logic        rpt_req;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         db_cnt <= '0;
      end else begin
         state  <= state_next;
         db_cnt <= db_cnt_next;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next  = state;
      db_cnt_next = '0;
      unique case (state)
         IDLE: begin
            if (sync) begin
               state_next  = DEB_PRESS;
               db_cnt_next = 16'd1;
            end
         end
         DEB_PRESS: begin
            if (!sync)                    state_next  = IDLE;
            else if (db_cnt == DB_LIMIT)  state_next  = HELD;
            else                          db_cnt_next = db_cnt + 16'd1;
         end
         HELD: begin
            if (!sync) begin
               state_next  = DEB_RELEASE;
               db_cnt_next = 16'd1;
            end
         end
         DEB_RELEASE: begin
            if (sync)                     state_next  = HELD;
            else if (db_cnt == DB_LIMIT)  state_next  = IDLE;
            else                          db_cnt_next = db_cnt + 16'd1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      press_req = (state == DEB_PRESS) && (state_next == HELD);
      held_next = (state_next == HELD) || (state_next == DEB_RELEASE);
      // The own-channel busy gate keeps two pulses from ever landing back to back.
      req       = (press_req || rpt_req) && !pulse_busy;
   end

`ifdef IIITB_BTN_AUTOREPEAT_EN
   localparam logic [15:0] RD_LOAD = 16'(REPEAT_DELAY);
   localparam logic [15:0] RP_LOAD = 16'(REPEAT_PERIOD);

   logic        in_hold;
   logic [15:0] rpt_cnt;

   assign in_hold = (state == HELD) || (state == DEB_RELEASE);

   // Counts down to the next repeat; a bounce back into HELD keeps the running phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rpt_cnt <= '0;
      end else if (press_req) begin
         rpt_cnt <= RD_LOAD;
      end else if (in_hold) begin
         rpt_cnt <= (rpt_cnt == 16'd1) ? RP_LOAD : rpt_cnt - 16'd1;
      end else begin
         rpt_cnt <= '0;
      end
   end

   assign rpt_req = in_hold && held_next && (rpt_cnt == 16'd1);
`else
   assign rpt_req = 1'b0;
`endif

endmodule

module iiitb_pwm_btn_cond #(
   parameter int DB_CYCLES     = 16,
   parameter int REPEAT_DELAY  = 64,
   parameter int REPEAT_PERIOD = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc_raw,
   input  logic dec_raw,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic inc_held,
   output logic dec_held
);

   logic inc_req;
   logic dec_req;
   logic inc_held_next;
   logic dec_held_next;

   iiitb_pwm_btn_cond_chan #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_inc (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (inc_raw),
      .pulse_busy (inc_pulse),
      .req        (inc_req),
      .held_next  (inc_held_next)
   );

   iiitb_pwm_btn_cond_chan #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_dec (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (dec_raw),
      .pulse_busy (dec_pulse),
      .req        (dec_req),
      .held_next  (dec_held_next)
   );

   // Coincident requests cancel each other; nothing is queued for later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inc_pulse <= 1'b0;
         dec_pulse <= 1'b0;
         inc_held  <= 1'b0;
         dec_held  <= 1'b0;
      end else begin
         inc_pulse <= inc_req && !dec_req;
         dec_pulse <= dec_req && !inc_req;
         inc_held  <= inc_held_next;
         dec_held  <= dec_held_next;
      end
   end

endmodule

// File: tb/tb_iiitb_pwm_btn_cond.sv
// Directed bench for iiitb_pwm_btn_cond with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Step k means raw inputs driven before rising edge k; outputs checked on the following falling edge.

module tb_iiitb_pwm_btn_cond;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic clk = 1'b0;
   logic reset_n;
   logic inc_raw;
   logic dec_raw;
   logic inc_pulse;
   logic dec_pulse;
   logic inc_held;
   logic dec_held;

   int checks = 0;
   int errors = 0;

   iiitb_pwm_btn_cond #(
      .DB_CYCLES     (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc_raw   (inc_raw),
      .dec_raw   (dec_raw),
      .inc_pulse (inc_pulse),
      .dec_pulse (dec_pulse),
      .inc_held  (inc_held),
      .dec_held  (dec_held)
   );

   always #5 clk = ~clk;

   // Observed vector is {inc_pulse, dec_pulse, inc_held, dec_held}.
   task automatic check(input string tag, input logic [3:0] expected);
      logic [3:0] observed;
      observed = {inc_pulse, dec_pulse, inc_held, dec_held};
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic step(input logic inc_in, input logic dec_in);
      inc_raw = inc_in;
      dec_raw = dec_in;
      @(negedge clk);
   endtask

   initial begin
      logic ep_i, ep_d, eh_i, eh_d;

      // Reset held with inputs toggling.
      reset_n = 1'b0;
      inc_raw = 1'b0;
      dec_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step(1'(k % 2), 1'((k / 2) % 2));
         check($sformatf("reset_toggle k=%0d", k), 4'b0000);
      end
      reset_n = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step(1'b0, 1'b0);
         check($sformatf("idle_after_reset k=%0d", k), 4'b0000);
      end

      // Clean increase press: raw high for steps 1..40, low afterwards.
      // Press pulse at 7; held 7..46 (first low edge 41, +6).
      for (int k = 1; k <= 50; k++) begin
         step(k <= 40, 1'b0);
         eh_i = (k >= 7) && (k < 47);
`ifdef IIITB_BTN_AUTOREPEAT_EN
         ep_i = (k == 7) || ((k >= 17) && (k < 47) && ((k - 17) % 5 == 0));
`else
         ep_i = (k == 7);
`endif
         check($sformatf("clean_press k=%0d", k), {ep_i, 1'b0, eh_i, 1'b0});
      end

      // Bounce on decrease: high 3, low 1, high 3, then low.
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, (k <= 3) || (k >= 5 && k <= 7));
         check($sformatf("bounce k=%0d", k), 4'b0000);
      end

      // Shortest accepted press on decrease: raw high steps 1..5, pulse at 7, held 7..11.
      for (int k = 1; k <= 15; k++) begin
         step(1'b0, k <= 5);
         ep_d = (k == 7);
         eh_d = (k >= 7) && (k < 12);
         check($sformatf("min_press k=%0d", k), {1'b0, ep_d, 1'b0, eh_d});
      end

      // Staggered presses one cycle apart: both pulses get through on adjacent cycles.
      for (int k = 1; k <= 22; k++) begin
         step(k <= 12, (k >= 2) && (k <= 12));
         eh_i = (k >= 7) && (k < 19);
         eh_d = (k >= 8) && (k < 19);
`ifdef IIITB_BTN_AUTOREPEAT_EN
         ep_i = (k == 7) || (k == 17);
         ep_d = (k == 8) || (k == 18);
`else
         ep_i = (k == 7);
         ep_d = (k == 8);
`endif
         check($sformatf("staggered k=%0d", k), {ep_i, ep_d, eh_i, eh_d});
      end

      // Simultaneous press: requests cancel, held flags still follow each channel.
      for (int k = 1; k <= 20; k++) begin
         step(k <= 10, k <= 10);
         eh_i = (k >= 7) && (k < 17);
         check($sformatf("simultaneous k=%0d", k), {1'b0, 1'b0, eh_i, eh_i});
      end

      // Reset while held: flags drop with no clock edge.
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b0);
         check($sformatf("pre_reset_hold k=%0d", k), {(k == 7), 1'b0, (k >= 7), 1'b0});
      end
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_async_drop", 4'b0000);
      step(1'b0, 1'b1);
      check("reset_mid_a", 4'b0000);
      step(1'b1, 1'b1);
      check("reset_mid_b", 4'b0000);
      step(1'b1, 1'b0);
      check("reset_mid_c", 4'b0000);
      reset_n = 1'b1;

      // Button still down after release: full debounce again, single pulse at 7.
      for (int k = 1; k <= 20; k++) begin
         step(k <= 10, 1'b0);
         eh_i = (k >= 7) && (k < 17);
         check($sformatf("post_reset_press k=%0d", k), {(k == 7), 1'b0, eh_i, 1'b0});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
